// File: rtl/tdc_meas_sequencer.sv
// Burst measurement sequencer for simple_tdc_core: start/stop/ack per shot, sum/count/min/max summary.
// Optional min/max tracking is enabled by defining TDC_SEQ_MINMAX_EN.
module tdc_meas_sequencer #(
   parameter int unsigned COARSE_WIDTH = 24,
   parameter int unsigned SHOT_WIDTH   = 8,
   parameter int unsigned TMO_WIDTH    = 24
) (
   input  logic                               clk_fast,
   input  logic                               rst,
   input  logic                               cmd_go,
   input  logic                               cmd_abort,
   input  logic [SHOT_WIDTH-1:0]              cfg_shots,
   input  logic [TMO_WIDTH-1:0]               cfg_timeout,
   input  logic                               hit_stop,
   output logic                               tdc_start,
   output logic                               tdc_stop,
   output logic                               tdc_ack,
   input  logic                               tdc_busy,
   input  logic                               tdc_valid,
   input  logic [COARSE_WIDTH-1:0]            tdc_coarse,
   output logic                               seq_busy,
   output logic                               res_valid,
   input  logic                               res_ready,
   output logic [COARSE_WIDTH+SHOT_WIDTH-1:0] res_sum,
   output logic [SHOT_WIDTH-1:0]              res_ok_count,
   output logic [SHOT_WIDTH-1:0]              res_tmo_count,
   output logic [COARSE_WIDTH-1:0]            res_min,
   output logic [COARSE_WIDTH-1:0]            res_max
);

   localparam int unsigned SUM_WIDTH = COARSE_WIDTH + SHOT_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_WAIT_STOP, S_WAIT_VALID, S_ACK, S_DRAIN, S_DONE
   } state_t;

   state_t                  state_q, state_nxt;
   logic [SHOT_WIDTH-1:0]   shots_q, shots_nxt;
   logic [TMO_WIDTH-1:0]    tmo_q, tmo_nxt;
   logic [TMO_WIDTH-1:0]    timer_q, timer_nxt;
   logic [SHOT_WIDTH-1:0]   shot_cnt_q, shot_cnt_nxt;
   logic                    shot_ok_q, shot_ok_nxt;
   logic                    abort_q, abort_nxt;
   logic                    start_nxt, stop_nxt, ack_nxt, busy_nxt, valid_nxt;
   logic [SUM_WIDTH-1:0]    sum_nxt;
   logic [SHOT_WIDTH-1:0]   ok_cnt_nxt, tmo_cnt_nxt;
`ifdef TDC_SEQ_MINMAX_EN
   logic [COARSE_WIDTH-1:0] min_q, min_nxt, max_q, max_nxt;
`endif

   // Next-state and registered-output computation
   always_comb begin
      state_nxt    = state_q;
      shots_nxt    = shots_q;
      tmo_nxt      = tmo_q;
      timer_nxt    = timer_q;
      shot_cnt_nxt = shot_cnt_q;
      shot_ok_nxt  = shot_ok_q;
      abort_nxt    = abort_q;
      start_nxt    = 1'b0;
      stop_nxt     = 1'b0;
      ack_nxt      = 1'b0;
      valid_nxt    = res_valid;
      sum_nxt      = res_sum;
      ok_cnt_nxt   = res_ok_count;
      tmo_cnt_nxt  = res_tmo_count;
`ifdef TDC_SEQ_MINMAX_EN
      min_nxt      = min_q;
      max_nxt      = max_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (cmd_go && (cfg_shots != '0)) begin
               shots_nxt    = cfg_shots;
               tmo_nxt      = cfg_timeout;
               shot_cnt_nxt = '0;
               abort_nxt    = 1'b0;
               sum_nxt      = '0;
               ok_cnt_nxt   = '0;
               tmo_cnt_nxt  = '0;
`ifdef TDC_SEQ_MINMAX_EN
               min_nxt      = '1;
               max_nxt      = '0;
`endif
               state_nxt    = S_ARM;
            end
         end
         S_ARM: begin
            if (cmd_abort) begin
               state_nxt = S_IDLE;
            end else if (!tdc_busy && !tdc_valid) begin
               start_nxt = 1'b1;
               timer_nxt = '0;
               state_nxt = S_WAIT_STOP;
            end
         end
         S_WAIT_STOP: begin
            timer_nxt = timer_q + TMO_WIDTH'(1);
            if (cmd_abort) begin
               stop_nxt  = 1'b1;
               state_nxt = S_DRAIN;
            end else if (hit_stop) begin
               stop_nxt    = 1'b1;
               shot_ok_nxt = 1'b1;
               state_nxt   = S_WAIT_VALID;
            end else if ((tmo_q != '0) && (timer_q == tmo_q - TMO_WIDTH'(1))) begin
               stop_nxt    = 1'b1;
               shot_ok_nxt = 1'b0;
               state_nxt   = S_WAIT_VALID;
            end
         end
         S_WAIT_VALID: begin
            // An abort here lets the shot finish, then drops the burst
            if (cmd_abort) begin
               abort_nxt = 1'b1;
            end
            if (tdc_valid) begin
               ack_nxt   = 1'b1;
               state_nxt = S_ACK;
               if (shot_ok_q) begin
                  sum_nxt    = res_sum + SUM_WIDTH'(tdc_coarse);
                  ok_cnt_nxt = res_ok_count + SHOT_WIDTH'(1);
`ifdef TDC_SEQ_MINMAX_EN
                  if (tdc_coarse < min_q) min_nxt = tdc_coarse;
                  if (tdc_coarse > max_q) max_nxt = tdc_coarse;
`endif
               end else begin
                  tmo_cnt_nxt = res_tmo_count + SHOT_WIDTH'(1);
               end
            end
         end
         S_ACK: begin
            shot_cnt_nxt = shot_cnt_q + SHOT_WIDTH'(1);
            if (abort_q || cmd_abort) begin
               state_nxt = S_IDLE;
            end else if (shot_cnt_q == shots_q - SHOT_WIDTH'(1)) begin
               valid_nxt = 1'b1;
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_ARM;
            end
         end
         S_DRAIN: begin
            if (tdc_valid) begin
               ack_nxt   = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               valid_nxt = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk_fast) begin
      if (rst) begin
         state_q       <= S_IDLE;
         shots_q       <= '0;
         tmo_q         <= '0;
         timer_q       <= '0;
         shot_cnt_q    <= '0;
         shot_ok_q     <= 1'b0;
         abort_q       <= 1'b0;
         tdc_start     <= 1'b0;
         tdc_stop      <= 1'b0;
         tdc_ack       <= 1'b0;
         seq_busy      <= 1'b0;
         res_valid     <= 1'b0;
         res_sum       <= '0;
         res_ok_count  <= '0;
         res_tmo_count <= '0;
`ifdef TDC_SEQ_MINMAX_EN
         min_q         <= '1;
         max_q         <= '0;
`endif
      end else begin
         state_q       <= state_nxt;
         shots_q       <= shots_nxt;
         tmo_q         <= tmo_nxt;
         timer_q       <= timer_nxt;
         shot_cnt_q    <= shot_cnt_nxt;
         shot_ok_q     <= shot_ok_nxt;
         abort_q       <= abort_nxt;
         tdc_start     <= start_nxt;
         tdc_stop      <= stop_nxt;
         tdc_ack       <= ack_nxt;
         seq_busy      <= busy_nxt;
         res_valid     <= valid_nxt;
         res_sum       <= sum_nxt;
         res_ok_count  <= ok_cnt_nxt;
         res_tmo_count <= tmo_cnt_nxt;
`ifdef TDC_SEQ_MINMAX_EN
         min_q         <= min_nxt;
         max_q         <= max_nxt;
`endif
      end
   end

`ifdef TDC_SEQ_MINMAX_EN
   assign res_min = min_q;
   assign res_max = max_q;
`else
   assign res_min = '0;
   assign res_max = '0;
`endif

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// Self-checking bench for tdc_meas_sequencer with a behavioural TDC core and a burst-level result model.
module tb_tdc_meas_sequencer;

   localparam int unsigned CW = 24;
   localparam int unsigned SW = 8;
   localparam int unsigned TW = 24;
   localparam logic [CW-1:0] ALL1 = '1;

   logic clk_fast = 1'b0;
   logic rst = 1'b1;
   logic cmd_go = 1'b0;
   logic cmd_abort = 1'b0;
   logic hit_stop = 1'b0;
   logic res_ready = 1'b0;
   logic [SW-1:0] cfg_shots = '0;
   logic [TW-1:0] cfg_timeout = '0;
   logic tdc_start, tdc_stop, tdc_ack, seq_busy, res_valid;
   logic core_busy = 1'b0;
   logic core_valid = 1'b0;
   logic [CW-1:0] core_coarse = '0;
   logic [CW+SW-1:0] res_sum;
   logic [SW-1:0] res_ok_count, res_tmo_count;
   logic [CW-1:0] res_min, res_max;

   int n_cmp = 0;
   int n_bad = 0;
   int plan_k[16];       // per shot: cycle after start in which hit_stop is driven, -1 = no hit
   int cur_tmo = 0;
   int shot_no = -1;
   int since = 0;
   bit stopped = 1'b1;
   bit free_mode = 1'b1;
   bit no_result = 1'b0;
   int n_start = 0, n_stop = 0, n_ack = 0;
   longint exp_sum = 0, exp_min = 0, exp_max = 0;
   int exp_ok = 0, exp_tmo = 0;
   int cyc = 0, core_t0 = 0, core_lat = 0;
   bit core_run = 1'b0;

   tdc_meas_sequencer dut (
      .clk_fast(clk_fast), .rst(rst), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
      .cfg_shots(cfg_shots), .cfg_timeout(cfg_timeout), .hit_stop(hit_stop),
      .tdc_start(tdc_start), .tdc_stop(tdc_stop), .tdc_ack(tdc_ack),
      .tdc_busy(core_busy), .tdc_valid(core_valid), .tdc_coarse(core_coarse),
      .seq_busy(seq_busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_ok_count(res_ok_count), .res_tmo_count(res_tmo_count),
      .res_min(res_min), .res_max(res_max)
   );

   always #5 clk_fast = ~clk_fast;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_off(input int s);
      if (s < 0 || s > 15) return -1;
      if (plan_k[s] >= 0) return plan_k[s] + 1;
      return cur_tmo;
   endfunction

   // Core model: coarse = (stop sample - start sample) - 2, result after 1..3 cycles, held until ack
   always @(posedge clk_fast) begin
      cyc <= cyc + 1;
      if (rst) begin
         core_busy  <= 1'b0;
         core_valid <= 1'b0;
         core_run   <= 1'b0;
         core_lat   <= 0;
      end else begin
         if (tdc_start && !core_busy) begin
            core_busy <= 1'b1;
            core_run  <= 1'b1;
            core_t0   <= cyc;
         end
         if (tdc_stop && core_run) begin
            core_run    <= 1'b0;
            core_lat    <= int'($urandom_range(1, 3));
            core_coarse <= (cyc - core_t0 >= 2) ? CW'(cyc - core_t0 - 2) : '0;
         end else if (core_lat != 0) begin
            core_lat <= core_lat - 1;
            if (core_lat == 1) core_valid <= 1'b1;
         end
         if (tdc_ack && core_valid) begin
            core_valid <= 1'b0;
            core_busy  <= 1'b0;
         end
      end
   end

   // Per-cycle compare process, also drives the planned hit_stop
   always @(negedge clk_fast) begin
      hit_stop = 1'b0;
      if (!rst) begin
         chk("pulse_excl", longint'((int'(tdc_start) + int'(tdc_stop) + int'(tdc_ack)) <= 1), 1);
         if (tdc_start) begin
            shot_no++;
            since   = 0;
            stopped = 1'b0;
            n_start++;
         end else begin
            since++;
         end
         if (tdc_stop) begin
            n_stop++;
            stopped = 1'b1;
            chk("busy_at_stop", longint'(seq_busy), 1);
            if (!free_mode) chk("stop_offset", since, exp_off(shot_no));
         end
         if (tdc_ack) n_ack++;
         if (!free_mode && !stopped && shot_no >= 0 && shot_no < 16 && plan_k[shot_no] == since)
            hit_stop = 1'b1;
         if (res_valid) begin
            chk("res_sum", longint'(res_sum), exp_sum);
            chk("res_ok", longint'(res_ok_count), exp_ok);
            chk("res_tmo", longint'(res_tmo_count), exp_tmo);
            chk("res_min", longint'(res_min), exp_min);
            chk("res_max", longint'(res_max), exp_max);
         end
         if (no_result) chk("no_result", longint'(res_valid), 0);
      end
   end

   task automatic pulse_go(input int shots, input int tmo);
      @(negedge clk_fast);
      cmd_go = 1'b1;
      cfg_shots = SW'(shots);
      cfg_timeout = TW'(tmo);
      @(negedge clk_fast);
      cmd_go = 1'b0;
   endtask

   task automatic clear_track();
      shot_no = -1;
      stopped = 1'b1;
      n_start = 0;
      n_stop  = 0;
      n_ack   = 0;
   endtask

   task automatic run_burst(input int shots, input int tmo, input int rdy_dly, input bit go_mid,
                            input bit pin, input longint p_sum, input int p_ok, input int p_tmo,
                            input longint p_min, input longint p_max);
      int w;
      longint mn, mx;
      exp_sum = 0; exp_ok = 0; exp_tmo = 0; mn = longint'(ALL1); mx = 0;
      for (int i = 0; i < shots; i++) begin
         if (plan_k[i] >= 0 && (tmo == 0 || plan_k[i] <= tmo - 1)) begin
            exp_sum += plan_k[i] - 1;
            exp_ok++;
            if (plan_k[i] - 1 < mn) mn = plan_k[i] - 1;
            if (plan_k[i] - 1 > mx) mx = plan_k[i] - 1;
         end else begin
            exp_tmo++;
         end
      end
`ifdef TDC_SEQ_MINMAX_EN
      exp_min = mn; exp_max = mx;
`else
      exp_min = 0; exp_max = 0;
`endif
      cur_tmo = tmo;
      clear_track();
      free_mode = 1'b0;
      no_result = 1'b0;
      pulse_go(shots, tmo);
      w = 0;
      while (!res_valid && w < 3000) begin
         @(negedge clk_fast);
         w++;
      end
      chk("res_valid_seen", longint'(res_valid), 1);
      chk("n_start", n_start, shots);
      chk("n_stop", n_stop, shots);
      chk("n_ack", n_ack, shots);
      if (pin) begin
         chk("lit_sum", longint'(res_sum), p_sum);
         chk("lit_ok", longint'(res_ok_count), p_ok);
         chk("lit_tmo", longint'(res_tmo_count), p_tmo);
`ifdef TDC_SEQ_MINMAX_EN
         chk("lit_min", longint'(res_min), p_min);
         chk("lit_max", longint'(res_max), p_max);
`else
         chk("lit_min", longint'(res_min), 0);
         chk("lit_max", longint'(res_max), 0);
`endif
      end
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk_fast);
         if (go_mid && i == 5) begin
            cmd_go = 1'b1;
            cfg_shots = SW'(3);
         end else begin
            cmd_go = 1'b0;
         end
      end
      cmd_go = 1'b0;
      chk("valid_held", longint'(res_valid), 1);
      chk("no_restart", n_start, shots);
      res_ready = 1'b1;
      @(negedge clk_fast);
      res_ready = 1'b0;
      chk("valid_cleared", longint'(res_valid), 0);
      chk("idle_busy", longint'(seq_busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int i = 0; i < 16; i++) plan_k[i] = -1;
      repeat (3) @(negedge clk_fast);
      chk("rst_start", longint'(tdc_start), 0);
      chk("rst_stop", longint'(tdc_stop), 0);
      chk("rst_ack", longint'(tdc_ack), 0);
      chk("rst_busy", longint'(seq_busy), 0);
      chk("rst_valid", longint'(res_valid), 0);
      chk("rst_sum", longint'(res_sum), 0);
`ifdef TDC_SEQ_MINMAX_EN
      chk("rst_min", longint'(res_min), longint'(ALL1));
`else
      chk("rst_min", longint'(res_min), 0);
`endif
      chk("rst_max", longint'(res_max), 0);
      rst = 1'b0;

      // Hits at 10, 20, 5 cycles after start, no timeout
      plan_k[0] = 10; plan_k[1] = 20; plan_k[2] = 5;
      run_burst(3, 0, 2, 1'b0, 1'b1, 32, 3, 0, 4, 19);
      // All shots time out after 8 cycles
      plan_k[0] = -1; plan_k[1] = -1;
      run_burst(2, 8, 1, 1'b0, 1'b1, 0, 0, 2, longint'(ALL1), 0);
      // Hit lands in the timeout cycle itself: counted OK
      plan_k[0] = 7;
      run_burst(1, 8, 0, 1'b0, 1'b1, 6, 1, 0, 6, 6);
      // Host stalls 20 cycles, cmd_go during DONE ignored, then a fresh burst is accepted
      plan_k[0] = 3;
      run_burst(1, 0, 20, 1'b1, 1'b0, 0, 0, 0, 0, 0);
      plan_k[0] = 4; plan_k[1] = 2;
      run_burst(2, 0, 0, 1'b0, 1'b1, 4, 2, 0, 1, 3);

      for (int b = 0; b < 25; b++) begin
         int shots, tmo;
         shots = int'($urandom_range(1, 4));
         tmo = ($urandom % 3 == 0) ? 0 : int'($urandom_range(2, 14));
         for (int i = 0; i < shots; i++) begin
            if (tmo == 0) plan_k[i] = int'($urandom_range(1, 20));
            else if ($urandom % 3 == 0) plan_k[i] = -1;
            else plan_k[i] = int'($urandom_range(1, tmo - 1));
         end
         run_burst(shots, tmo, int'($urandom_range(0, 4)), 1'b0, 1'b0, 0, 0, 0, 0, 0);
      end

      // Abort while waiting for the stop
      for (int i = 0; i < 16; i++) plan_k[i] = -1;
      clear_track();
      free_mode = 1'b1;
      no_result = 1'b1;
      pulse_go(2, 0);
      w = 0;
      while (!tdc_start && w < 100) begin
         @(negedge clk_fast);
         w++;
      end
      chk("abort_start_seen", longint'(tdc_start), 1);
      repeat (3) @(negedge clk_fast);
      cmd_abort = 1'b1;
      @(negedge clk_fast);
      cmd_abort = 1'b0;
      repeat (30) @(negedge clk_fast);
      chk("abort_n_start", n_start, 1);
      chk("abort_n_stop", n_stop, 1);
      chk("abort_n_ack", n_ack, 1);
      chk("abort_busy", longint'(seq_busy), 0);
      chk("abort_core_valid", longint'(core_valid), 0);
      chk("abort_core_busy", longint'(core_busy), 0);

      // Reset while waiting for the core result
      plan_k[0] = 5; plan_k[1] = 5;
      cur_tmo = 0;
      clear_track();
      free_mode = 1'b0;
      pulse_go(2, 0);
      w = 0;
      while (!tdc_stop && w < 200) begin
         @(negedge clk_fast);
         w++;
      end
      chk("rst_test_stop_seen", longint'(tdc_stop), 1);
      rst = 1'b1;
      @(negedge clk_fast);
      chk("mid_rst_start", longint'(tdc_start), 0);
      chk("mid_rst_stop", longint'(tdc_stop), 0);
      chk("mid_rst_ack", longint'(tdc_ack), 0);
      chk("mid_rst_busy", longint'(seq_busy), 0);
      chk("mid_rst_valid", longint'(res_valid), 0);
      chk("mid_rst_ok", longint'(res_ok_count), 0);
      chk("mid_rst_tmo", longint'(res_tmo_count), 0);
      rst = 1'b0;
      free_mode = 1'b1;
      for (int i = 0; i < 16; i++) plan_k[i] = -1;
      clear_track();
      pulse_go(0, 0);
      repeat (15) @(negedge clk_fast);
      chk("zero_shots_start", n_start, 0);
      chk("zero_shots_busy", longint'(seq_busy), 0);
      no_result = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
